addsub_serial: RTL
==================

// Module: addsub_serial
// PURPOSE
//  Multi-cycle, chunk-serial two's-complement adder/subtractor. It is the parametrised
//  successor of the 5-bit ripple add/sub unit.
//  Computes S = X + Y or X - Y over WIDTH bits, processing CHUNK bits per clock.
//  Flags: carry-out C, signed overflow E, zero Z.
//  Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; >= 2
//  CHUNK  2  bits added per cycle; 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0
//  (derived) NCHUNK = WIDTH/CHUNK; chunk counter width = $clog2(NCHUNK)+1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      unit can accept operands
//  x          in   WIDTH  operand X
//  y          in   WIDTH  operand Y
//  sub        in   1      0: X+Y, 1: X-Y
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  s          out  WIDTH  result
//  c          out  1      carry out of MSB (for sub: 1 = no borrow)
//  e          out  1      signed overflow = carry-into-MSB ^ carry-out-of-MSB
//  z          out  1      s == 0
// BEHAVIOUR
//  Single clock domain. Reset is asynchronous and active-low.
//  On rst_n=0: state=IDLE, in_ready=1, out_valid=0, s=0, c=0, e=0, z=0; internal operand/carry regs cleared.
//  FSM states IDLE, RUN and DONE:
//   IDLE: in_ready=1. When in_valid=1 at a clk edge:
//    - latch x, y^{WIDTH{sub}}, and carry=sub (C0=sub);
//    - set chunk index k=0; go to RUN.
//   RUN: in_ready=0. Each cycle, add chunk k: bits [k*CHUNK +: CHUNK] of X and ~Y/Y plus the carry.
//    - write the sum bits into s; update the carry; k++.
//    - on the last chunk (k==NCHUNK-1), also capture the carry into bit WIDTH-1 (for e). Then go to DONE.
//   DONE: out_valid=1, and s/c/e/z are stable. On out_ready=1, go to IDLE and clear out_valid.
//  Latency: out_valid rises exactly NCHUNK cycles after the accepting edge.
//  Throughput: one operation per NCHUNK+2 cycles. in_ready is asserted only in IDLE.
//  in_valid while not in IDLE is ignored. Operands are sampled only on the accepting edge;
//  later changes on x/y/sub have no effect.
//  out_valid=1 with out_ready=0: hold all outputs indefinitely (no loss, no change).
//  s is undefined-but-stable during RUN; consumers must qualify with out_valid.
//  Arithmetic is modulo 2^WIDTH. c = final carry. e = c ^ carry-into-MSB. z = (s == 0) on the final s.
//  Wrap-around example: X=2^WIDTH-1, Y=1, add -> s=0, c=1, z=1.
//  Reset asserted mid-RUN or in DONE: the operation is abandoned, state goes to IDLE, and no out_valid is produced.
//  CHUNK == WIDTH is legal: RUN lasts one cycle.
// CONFIGURATION
//  ADDSUB_SAT_EN defined:
//   - When e=1, s saturates to the signed limit: +max (0111..1) if X's MSB was 0, else -min (1000..0).
//   - c and e still report the unsaturated arithmetic. z is computed on the saturated s.
//  ADDSUB_SAT_EN undefined: s is the modulo result. No saturation logic is synthesised.
// TESTING  (WIDTH=8, CHUNK=2 unless noted)
//  1. X=15, Y=10, sub=0 -> s=0x19 (25), c=0, e=0, z=0. out_valid exactly 4 cycles after accept.
//  2. X=100, Y=100, sub=0 -> s=0xC8, c=0, e=1; with ADDSUB_SAT_EN, s=0x7F, e=1.
//  3. X=5, Y=10, sub=1 -> s=0xFB, c=0, e=0. Also X=10, Y=10, sub=1 -> s=0x00, c=1, z=1.
//  4. X=0x80, Y=0x01, sub=1 -> s=0x7F, c=1, e=1; with ADDSUB_SAT_EN, s=0x80.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle x/y/in_valid.
//     -> outputs stable, in_ready=0, no new accept. Result consumed on the first out_ready=1. in_ready=1 the next cycle.
//  6. Assert rst_n=0 at chunk k=2 -> same-cycle out_valid=0, in_ready=1, s=0.
//     A subsequent op 0xFF+0x01 -> s=0, c=1, z=1. Repeat with CHUNK=1 (latency 8) and CHUNK=8 (latency 1).

Source files
------------

// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for addsub_serial.
// master = operand producer + result consumer, slave = the arithmetic unit.
interface addsub_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             e;
  logic             z;

  modport master (
    output in_valid, x, y, sub, out_ready,
    input  in_ready, out_valid, s, c, e, z
  );

  modport slave (
    input  in_valid, x, y, sub, out_ready,
    output in_ready, out_valid, s, c, e, z
  );
endinterface

// File: rtl/addsub_serial.sv
// Chunk-serial two's-complement add/sub: CHUNK bits per clock, flags c/e/z.
// Define ADDSUB_SAT_EN to saturate s to the signed limit on overflow.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  addsub_serial_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = $clog2(NCHUNK) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] xr, yr, sr;
  logic             carry;
  logic             cr, er, zr;
  logic [KW-1:0]    k;

  int               off;
  logic             last;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] s_mod, s_fin;
  logic             msb_cin, e_fin;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of an always_comb gets a default first; any path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Chunk adder and final-result formation
  // ---------------------------------------------------------------------------
  always_comb begin
    off   = int'(k) * CHUNK;
    last  = (k == KW'(NCHUNK - 1));
    csum  = {1'b0, xr[off +: CHUNK]} + {1'b0, yr[off +: CHUNK]} + {{CHUNK{1'b0}}, carry};
    s_mod = sr;
    s_mod[off +: CHUNK] = csum[CHUNK-1:0];
    // Carry into the MSB recovered from the MSB full-adder: sum = a ^ b ^ cin.
    msb_cin = xr[WIDTH-1] ^ yr[WIDTH-1] ^ s_mod[WIDTH-1];
    e_fin   = csum[CHUNK] ^ msb_cin;
    s_fin   = s_mod;
`ifdef ADDSUB_SAT_EN
    // Overflow direction follows the sign of X: positive X can only overflow upward.
    if (e_fin) begin
      s_fin = xr[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: all datapath registers are reset so an abandoned operation leaves
  // no stale result or carry visible after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr    <= '0;
      yr    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      cr    <= 1'b0;
      er    <= 1'b0;
      zr    <= 1'b0;
      k     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xr    <= bus.x;
            // Subtraction as X + ~Y + 1: invert Y here, inject the +1 as C0.
            yr    <= bus.y ^ {WIDTH{bus.sub}};
            carry <= bus.sub;
            k     <= '0;
          end
        end
        RUN: begin
          carry <= csum[CHUNK];
          k     <= k + 1'b1;
          if (last) begin
            sr <= s_fin;
            cr <= csum[CHUNK];
            er <= e_fin;
            zr <= (s_fin == '0);
          end else begin
            sr <= s_mod;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s = sr;
  assign bus.c = cr;
  assign bus.e = er;
  assign bus.z = zr;

endmodule
